// File: rtl/count_sched_pkg.sv
// Shared types and default widths for the count scheduler.
package count_sched_pkg;
    localparam int W_COE_DEF = 8;
    localparam int LW_DEF    = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;
endpackage

// File: rtl/count_rr_arb.sv
// Two-input round-robin arbiter: the requester other than the last-granted one wins ties.
module count_rr_arb (
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       last,
    output logic [1:0] gnt
);
    logic [1:0] elig;

    assign elig = req & ~mask;

    always_comb begin
        gnt = 2'b00;
        case (elig)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end
endmodule

// File: rtl/count_sched.sv
// Schedules counting jobs from two requesters onto one external counter datapath.
module count_sched
    import count_sched_pkg::*;
#(
    parameter int W_COE = W_COE_DEF,
    parameter int LW    = LW_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         req,
    input  logic [2*W_COE-1:0] req_start,
    input  logic [2*W_COE-1:0] req_step,
    input  logic [2*LW-1:0]    req_len,
    output logic [1:0]         gnt,
    output logic               cnt_load,
    output logic [W_COE-1:0]   cnt_load_val,
    output logic [W_COE-1:0]   cnt_step,
    output logic               cnt_en,
    input  logic [W_COE-1:0]   cnt_val,
    output logic [1:0]         done,
    output logic [W_COE-1:0]   result,
    output logic               busy
);
    logic [W_COE-1:0] start_arr [2];
    logic [W_COE-1:0] step_arr  [2];
    logic [LW-1:0]    len_arr   [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_unpack
        assign start_arr[gi] = req_start[gi*W_COE +: W_COE];
        assign step_arr[gi]  = req_step[gi*W_COE +: W_COE];
        assign len_arr[gi]   = req_len[gi*LW +: LW];
    end

    state_t           state_reg, state_next;
    logic             owner_reg, owner_next;
    logic             last_reg, last_next;
    logic [LW-1:0]    len_reg, len_next;
    logic [1:0]       gnt_reg, gnt_next;
    logic             cnt_load_reg, cnt_load_next;
    logic             cnt_en_reg, cnt_en_next;
    logic [W_COE-1:0] load_val_reg, load_val_next;
    logic [W_COE-1:0] step_reg, step_next;
    logic [1:0]       done_reg, done_next;
    logic [W_COE-1:0] result_reg, result_next;
    logic [1:0]       arb_gnt;

    // A requester whose done pulse is still high cannot be re-granted that cycle.
    count_rr_arb u_arb (
        .req  (req),
        .mask (done_reg),
        .last (last_reg),
        .gnt  (arb_gnt)
    );

    always_comb begin
        state_next    = state_reg;
        owner_next    = owner_reg;
        last_next     = last_reg;
        len_next      = len_reg;
        load_val_next = load_val_reg;
        step_next     = step_reg;
        result_next   = result_reg;
        done_next     = 2'b00;
        case (state_reg)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    state_next    = ST_LOAD;
                    owner_next    = arb_gnt[1];
                    last_next     = arb_gnt[1];
                    len_next      = len_arr[arb_gnt[1]];
                    load_val_next = start_arr[arb_gnt[1]];
                    step_next     = step_arr[arb_gnt[1]];
                end
            end
            ST_LOAD: begin
                if (!req[owner_reg])
                    state_next = ST_IDLE;
                else if (len_reg == '0)
                    state_next = ST_DONE;
                else
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!req[owner_reg]) begin
                    state_next = ST_IDLE;
                end else begin
                    len_next = len_reg - LW'(1);
                    if (len_reg == LW'(1))
                        state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next           = ST_IDLE;
                done_next[owner_reg] = 1'b1;
                result_next          = cnt_val;
            end
            default: state_next = ST_IDLE;
        endcase
        // Outputs are registered from the next state so they line up with the state they describe.
        gnt_next      = (state_next != ST_IDLE) ? (2'b01 << owner_next) : 2'b00;
        cnt_load_next = (state_next == ST_LOAD);
        cnt_en_next   = (state_next == ST_RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= 1'b0;
            last_reg     <= 1'b1;
            len_reg      <= '0;
            gnt_reg      <= 2'b00;
            cnt_load_reg <= 1'b0;
            cnt_en_reg   <= 1'b0;
            load_val_reg <= '0;
            step_reg     <= '0;
            done_reg     <= 2'b00;
            result_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            last_reg     <= last_next;
            len_reg      <= len_next;
            gnt_reg      <= gnt_next;
            cnt_load_reg <= cnt_load_next;
            cnt_en_reg   <= cnt_en_next;
            load_val_reg <= load_val_next;
            step_reg     <= step_next;
            done_reg     <= done_next;
            result_reg   <= result_next;
        end
    end

    assign gnt          = gnt_reg;
    assign cnt_load     = cnt_load_reg;
    assign cnt_load_val = load_val_reg;
    assign cnt_step     = step_reg;
    assign cnt_en       = cnt_en_reg;
    assign done         = done_reg;
    assign result       = result_reg;
    assign busy         = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_count_sched.sv
// Directed bench for count_sched with a behavioural model of the external counter.
module tb_count_sched;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] req_start = '0;
    logic [15:0] req_step = '0;
    logic [15:0] req_len = '0;
    logic [1:0]  gnt;
    logic        cnt_load;
    logic [7:0]  cnt_load_val;
    logic [7:0]  cnt_step;
    logic        cnt_en;
    logic [7:0]  cnt_val;
    logic [1:0]  done;
    logic [7:0]  result;
    logic        busy;

    int tests = 0;
    int fails = 0;

    int n_g0, n_g1, n_en, n_ld, d0_at, d1_at;
    logic [7:0] r0, r1;

    count_sched #(.W_COE(8), .LW(8)) dut (
        .clock(clock), .reset(reset), .req(req), .req_start(req_start),
        .req_step(req_step), .req_len(req_len), .gnt(gnt), .cnt_load(cnt_load),
        .cnt_load_val(cnt_load_val), .cnt_step(cnt_step), .cnt_en(cnt_en),
        .cnt_val(cnt_val), .done(done), .result(result), .busy(busy)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)         cnt_val <= 8'h00;
        else if (cnt_load) cnt_val <= cnt_load_val;
        else if (cnt_en)   cnt_val <= cnt_val + cnt_step;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Watch ncyc cycles; drop a requester's req when its done pulse appears.
    task automatic observe(input int ncyc, input bit scramble);
        n_g0 = 0; n_g1 = 0; n_en = 0; n_ld = 0; d0_at = 0; d1_at = 0;
        r0 = 8'hxx; r1 = 8'hxx;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clock);
            if (gnt[0]) n_g0++;
            if (gnt[1]) n_g1++;
            if (cnt_en) n_en++;
            if (cnt_load) n_ld++;
            if (done[0] && d0_at == 0) begin d0_at = k; r0 = result; req[0] = 1'b0; end
            if (done[1] && d1_at == 0) begin d1_at = k; r1 = result; req[1] = 1'b0; end
            if (scramble && k == 1) begin
                req_start = 16'hA5A5; req_step = 16'h7777; req_len = 16'h3333;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_load", cnt_load, 1'b0);
        chk("rst_en", cnt_en, 1'b0);
        chk("rst_lval", cnt_load_val, 8'h00);
        chk("rst_step", cnt_step, 8'h00);
        chk("rst_result", result, 8'h00);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        @(negedge clock);

        // Basic job, inputs scrambled after latching.
        req_start = 16'h000F; req_step = 16'h0001; req_len = 16'h0004; req = 2'b01;
        observe(12, 1'b1);
        chk("t1_gnt0_cycles", n_g0, 6);
        chk("t1_en_cycles", n_en, 4);
        chk("t1_load_cycles", n_ld, 1);
        chk("t1_done0_at", d0_at, 7);
        chk("t1_result", r0, 8'h13);
        chk("t1_busy_end", busy, 1'b0);

        // Wrap without saturation.
        req_start = 16'h00FE; req_step = 16'h0003; req_len = 16'h0002; req = 2'b01;
        observe(10, 1'b0);
        chk("t2_done0_at", d0_at, 5);
        chk("t2_result", r0, 8'h04);
        chk("t2_en_cycles", n_en, 2);

        // Both requesters after a fresh reset.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        req_start = 16'h2010; req_step = 16'h0102; req_len = 16'h0301; req = 2'b11;
        observe(14, 1'b0);
        chk("t3_done0_at", d0_at, 4);
        chk("t3_done1_at", d1_at, 10);
        chk("t3_result0", r0, 8'h12);
        chk("t3_result1", r1, 8'h23);
        chk("t3_gnt0_cycles", n_g0, 3);
        chk("t3_gnt1_cycles", n_g1, 5);

        // Zero length job.
        req_start = 16'h0055; req_step = 16'h0001; req_len = 16'h0000; req = 2'b01;
        observe(8, 1'b0);
        chk("t4_done0_at", d0_at, 3);
        chk("t4_en_cycles", n_en, 0);
        chk("t4_load_cycles", n_ld, 1);
        chk("t4_result", r0, 8'h55);

        // Abort in the second RUN cycle with requester 1 pending.
        req_start = 16'h4000; req_step = 16'h0101; req_len = 16'h0105; req = 2'b01;
        @(negedge clock);
        chk("t5_k1_load", cnt_load, 1'b1);
        chk("t5_k1_gnt", gnt, 2'b01);
        req = 2'b11;
        @(negedge clock);
        chk("t5_k2_en", cnt_en, 1'b1);
        @(negedge clock);
        chk("t5_k3_en", cnt_en, 1'b1);
        req = 2'b10;
        @(negedge clock);
        chk("t5_k4_en", cnt_en, 1'b0);
        chk("t5_k4_gnt", gnt, 2'b00);
        chk("t5_k4_busy", busy, 1'b0);
        chk("t5_k4_done", done, 2'b00);
        chk("t5_k4_result", result, 8'h55);
        @(negedge clock);
        chk("t5_k5_gnt", gnt, 2'b10);
        chk("t5_k5_lval", cnt_load_val, 8'h40);
        @(negedge clock);
        chk("t5_k6_en", cnt_en, 1'b1);
        @(negedge clock);
        chk("t5_k7_en", cnt_en, 1'b0);
        chk("t5_k7_gnt", gnt, 2'b10);
        @(negedge clock);
        chk("t5_k8_done", done, 2'b10);
        chk("t5_k8_result", result, 8'h41);
        req = 2'b00;
        @(negedge clock);

        // Reset during RUN.
        req_start = 16'h0000; req_step = 16'h0001; req_len = 16'h0006; req = 2'b01;
        repeat (2) @(negedge clock);
        chk("t6_run_en", cnt_en, 1'b1);
        reset = 1'b1;
        req = 2'b00;
        #1;
        chk("t6_rst_gnt", gnt, 2'b00);
        chk("t6_rst_en", cnt_en, 1'b0);
        chk("t6_rst_lval", cnt_load_val, 8'h00);
        chk("t6_rst_step", cnt_step, 8'h00);
        chk("t6_rst_result", result, 8'h00);
        chk("t6_rst_busy", busy, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        observe(10, 1'b0);
        chk("t6_no_done0", d0_at, 0);
        chk("t6_no_gnt", n_g0 + n_g1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
